// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII MAC/PHY bridge.
package rgmii_pkg;
   typedef logic [3:0] nibble_t;
   typedef logic [7:0] byte_t;
   localparam int RGMII_CLK_PERIOD_NS = 8;
endpackage

// File: rtl/rgmii_ddr_out.sv
// One-bit DDR output: d0 drives the high phase and d1 the low phase that follow each rising edge.
// Build with RGMII_LATTICE_DDR_EN to map onto the Lattice ODDRX1F primitive.
module rgmii_ddr_out (
   input  logic clk,
   input  logic rst,
   input  logic d0,
   input  logic d1,
   output logic q
);
`ifdef RGMII_LATTICE_DDR_EN
   ODDRX1F u_oddr (
      .SCLK (clk),
      .RST  (rst),
      .D0   (d0),
      .D1   (d1),
      .Q    (q)
   );
`else
   logic d0_q, d0_d;
   logic d1_q, d1_d;

   always_comb begin
      d0_d = d0;
      d1_d = d1;
   end

   // Both phases are captured on the rising edge, so the low-phase value
   // belongs to the same byte as the high-phase value before it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0_q <= 1'b0;
         d1_q <= 1'b0;
      end else begin
         d0_q <= d0_d;
         d1_q <= d1_d;
      end
   end

   assign q = clk ? d0_q : d1_q;
`endif
endmodule

// File: rtl/rgmii_mac_phy_if.sv
// Byte-wide application <-> 4-bit DDR RGMII bridge on a single 125 MHz clock.
// Build with RGMII_LATTICE_DDR_EN for Lattice IDDRX1F/ODDRX1F primitives; default is behavioural DDR.
module rgmii_mac_phy_if
   import rgmii_pkg::*;
#(
   parameter nibble_t TX_IDLE_NIBBLE   = 4'h0,
   parameter int      RX_ER_AS_INVALID = 1
) (
   input  logic       ETH_REFCLK,
   input  logic       RESET,
   output logic [7:0] RX_DATA,
   output logic       RX_DV,
   input  logic [7:0] TX_DATA,
   input  logic       TX_DV,
   input  logic       RGMII_RX_CTL,
   input  logic [3:0] RGMII_RX_D,
   output logic       RGMII_TX_CLK,
   output logic       RGMII_TX_CTL,
   output logic [3:0] RGMII_TX_D,
   output logic       MDIO_CLK,
   inout  wire        MDIO_DATA
);
   // Handshake: RX_DV and TX_DV are valid-only strobes; each cycle they are
   // high carries exactly one byte and there is no back-pressure either way.
   localparam logic ER_DROP = (RX_ER_AS_INVALID != 0);

   logic    ctl_r_s, ctl_f_s;
   nibble_t lo_s, hi_s;

`ifdef RGMII_LATTICE_DDR_EN
   IDDRX1F u_iddr_ctl (
      .D    (RGMII_RX_CTL),
      .SCLK (ETH_REFCLK),
      .RST  (RESET),
      .Q0   (ctl_r_s),
      .Q1   (ctl_f_s)
   );
   for (genvar i = 0; i < 4; i++) begin : g_iddr
      IDDRX1F u_iddr (
         .D    (RGMII_RX_D[i]),
         .SCLK (ETH_REFCLK),
         .RST  (RESET),
         .Q0   (lo_s[i]),
         .Q1   (hi_s[i])
      );
   end
`else
   logic    ctl_r_q, ctl_r_d, ctl_f_q, ctl_f_d;
   nibble_t lo_q, lo_d, hi_q, hi_d;

   always_comb begin
      ctl_r_d = RGMII_RX_CTL;
      lo_d    = RGMII_RX_D;
      ctl_f_d = RGMII_RX_CTL;
      hi_d    = RGMII_RX_D;
   end

   always_ff @(posedge ETH_REFCLK or posedge RESET) begin
      if (RESET) begin
         ctl_r_q <= 1'b0;
         lo_q    <= '0;
      end else begin
         ctl_r_q <= ctl_r_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(negedge ETH_REFCLK or posedge RESET) begin
      if (RESET) begin
         ctl_f_q <= 1'b0;
         hi_q    <= '0;
      end else begin
         ctl_f_q <= ctl_f_d;
         hi_q    <= hi_d;
      end
   end

   assign ctl_r_s = ctl_r_q;
   assign ctl_f_s = ctl_f_q;
   assign lo_s    = lo_q;
   assign hi_s    = hi_q;
`endif

   byte_t rx_data_q, rx_data_d;
   logic  rx_dv_q, rx_dv_d;
   byte_t tx_byte_q, tx_byte_d;
   logic  tx_v_q, tx_v_d;

   // The falling CTL carries DV^ER, so a rising/falling mismatch flags an error.
   // Gating on ctl_r keeps undriven data during idle out of the valid path.
   always_comb begin
      rx_dv_d   = ctl_r_s & ~(ER_DROP & (ctl_r_s ^ ctl_f_s));
      rx_data_d = rx_dv_d ? {hi_s, lo_s} : rx_data_q;
      tx_v_d    = TX_DV;
      tx_byte_d = TX_DV ? TX_DATA : {TX_IDLE_NIBBLE, TX_IDLE_NIBBLE};
   end

   always_ff @(posedge ETH_REFCLK or posedge RESET) begin
      if (RESET) begin
         rx_data_q <= '0;
         rx_dv_q   <= 1'b0;
         tx_byte_q <= '0;
         tx_v_q    <= 1'b0;
      end else begin
         rx_data_q <= rx_data_d;
         rx_dv_q   <= rx_dv_d;
         tx_byte_q <= tx_byte_d;
         tx_v_q    <= tx_v_d;
      end
   end

   assign RX_DATA = rx_data_q;
   assign RX_DV   = rx_dv_q;

   // TX_CLK is produced by the same DDR cell type so it stays edge-aligned with data.
   rgmii_ddr_out u_ddr_clk (
      .clk (ETH_REFCLK),
      .rst (RESET),
      .d0  (1'b1),
      .d1  (1'b0),
      .q   (RGMII_TX_CLK)
   );

   rgmii_ddr_out u_ddr_ctl (
      .clk (ETH_REFCLK),
      .rst (RESET),
      .d0  (tx_v_q),
      .d1  (tx_v_q),
      .q   (RGMII_TX_CTL)
   );

   for (genvar i = 0; i < 4; i++) begin : g_tx_d
      rgmii_ddr_out u_ddr_d (
         .clk (ETH_REFCLK),
         .rst (RESET),
         .d0  (tx_byte_q[i]),
         .d1  (tx_byte_q[i+4]),
         .q   (RGMII_TX_D[i])
      );
   end

   assign MDIO_CLK  = 1'b0;
   assign MDIO_DATA = 1'bz;
endmodule

// File: tb/tb_rgmii_mac_phy_if.sv
// Self-checking bench for rgmii_mac_phy_if: two instances (error-drop / error-pass, idle 0 / idle 9)
// driven in lock-step against a per-cycle behavioural model.
module tb_rgmii_mac_phy_if;
   import rgmii_pkg::*;

   localparam logic [3:0] IDLE0 = 4'h0;
   localparam logic [3:0] IDLE1 = 4'h9;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_dv = 1'b0;
   logic       rx_ctl = 1'b0;
   logic [3:0] rx_d = '0;

   initial forever #(RGMII_CLK_PERIOD_NS / 2) clk = ~clk;

   logic [7:0] rx_data0, rx_data1;
   logic       rx_dv0, rx_dv1;
   logic       tx_clk0, tx_clk1, tx_ctl0, tx_ctl1;
   logic [3:0] tx_d0, tx_d1;
   logic       mdio_clk0, mdio_clk1;
   wire        mdio0, mdio1;
   pullup (mdio0);
   pullup (mdio1);

`ifdef RGMII_LATTICE_DDR_EN
   GSR GSR_INST (.GSR(1'b1));
   PUR PUR_INST (.PUR(1'b1));
`endif

   rgmii_mac_phy_if #(.TX_IDLE_NIBBLE(IDLE0), .RX_ER_AS_INVALID(1)) u_dut (
      .ETH_REFCLK   (clk),
      .RESET        (rst),
      .RX_DATA      (rx_data0),
      .RX_DV        (rx_dv0),
      .TX_DATA      (tx_data),
      .TX_DV        (tx_dv),
      .RGMII_RX_CTL (rx_ctl),
      .RGMII_RX_D   (rx_d),
      .RGMII_TX_CLK (tx_clk0),
      .RGMII_TX_CTL (tx_ctl0),
      .RGMII_TX_D   (tx_d0),
      .MDIO_CLK     (mdio_clk0),
      .MDIO_DATA    (mdio0)
   );

   rgmii_mac_phy_if #(.TX_IDLE_NIBBLE(IDLE1), .RX_ER_AS_INVALID(0)) u_dut_pass (
      .ETH_REFCLK   (clk),
      .RESET        (rst),
      .RX_DATA      (rx_data1),
      .RX_DV        (rx_dv1),
      .TX_DATA      (tx_data),
      .TX_DV        (tx_dv),
      .RGMII_RX_CTL (rx_ctl),
      .RGMII_RX_D   (rx_d),
      .RGMII_TX_CLK (tx_clk1),
      .RGMII_TX_CTL (tx_ctl1),
      .RGMII_TX_D   (tx_d1),
      .MDIO_CLK     (mdio_clk1),
      .MDIO_DATA    (mdio1)
   );

   // ---------------- scoreboard / model ----------------
   int checks = 0;
   int failures = 0;

   // Previous cycle's stimulus: every byte surfaces one cycle after it is driven.
   bit         pend_r, pend_f, pend_tdv, pend_tx_reset;
   logic [7:0] pend_b, pend_tdata;
   bit         exp_dv [2];
   logic [7:0] exp_data [2];
   bit         exp_tv;
   logic [7:0] exp_tb [2];
   logic [3:0] idle_nib [2];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend_r = 0; pend_f = 0; pend_tdv = 0; pend_tx_reset = 1;
      pend_b = '0; pend_tdata = '0;
      for (int j = 0; j < 2; j++) begin
         exp_dv[j] = 0; exp_data[j] = '0; exp_tb[j] = '0;
      end
      exp_tv = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_data"}, rx_data0, 8'h00);
      check({tag, "_rx_dv"},   {7'd0, rx_dv0},  8'h00);
      check({tag, "_tx_clk"},  {7'd0, tx_clk0}, 8'h00);
      check({tag, "_tx_ctl"},  {7'd0, tx_ctl0}, 8'h00);
      check({tag, "_tx_d"},    {4'd0, tx_d0},   8'h00);
      check({tag, "_tx_d_b"},  {4'd0, tx_d1},   8'h00);
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset(input int n);
      rst = 1'b1;
      rx_ctl = 1'b0; rx_d = 4'bx; tx_dv = 1'b0; tx_data = '0;
      #1;
      check_all_zero("rst");
      check("rst_mdio_clk", {6'd0, mdio_clk1, mdio_clk0}, 8'h00);
      check("rst_mdio_z", {6'd0, mdio1, mdio0}, 8'h03);
      repeat (n) begin
         @(posedge clk); #2;
         check("rst_hold_tx_clk", {6'd0, tx_clk1, tx_clk0}, 8'h00);
         check("rst_hold_rx_dv", {6'd0, rx_dv1, rx_dv0}, 8'h00);
      end
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check("rel_tx_clk_static", {7'd0, tx_clk0}, 8'h00);
      model_reset();
   endtask

   // One cycle: rising-edge half (r, lo) then falling-edge half (f, hi) on RX,
   // one application byte on TX; outputs compared in both clock phases.
   task automatic step(input bit r, input bit f, input logic [7:0] b,
                       input bit tdv, input logic [7:0] tdata,
                       input bit loopback, input bit mid_rst);
      bit         m_tdv;
      logic [7:0] m_tdata;
      logic [7:0] drv_b;
      drv_b = (r || f) ? b : 8'bx;
      if (loopback) begin
         tx_dv = rx_dv0; tx_data = rx_data0;
         m_tdv = exp_dv[0]; m_tdata = exp_data[0];
      end else begin
         tx_dv = tdv; tx_data = tdata;
         m_tdv = tdv; m_tdata = tdata;
      end
      rx_ctl = r; rx_d = drv_b[3:0];

      // RX: delivered when valid and either error-free or errors are passed through.
      exp_dv[0] = pend_r && (pend_r == pend_f);
      exp_dv[1] = pend_r;
      for (int j = 0; j < 2; j++) begin
         if (exp_dv[j]) exp_data[j] = pend_b;
         if (pend_tx_reset) exp_tb[j] = '0;
         else exp_tb[j] = pend_tdv ? pend_tdata : {idle_nib[j], idle_nib[j]};
      end
      exp_tv = pend_tdv;
      pend_tx_reset = 0;
      pend_r = r; pend_f = f; pend_b = b; pend_tdv = m_tdv; pend_tdata = m_tdata;

      @(posedge clk); #2;
      check("hi_tx_clk", {6'd0, tx_clk1, tx_clk0}, 8'h03);
      check("hi_tx_ctl", {6'd0, tx_ctl1, tx_ctl0}, {6'd0, exp_tv, exp_tv});
      check("hi_tx_d0", {4'd0, tx_d0}, {4'd0, exp_tb[0][3:0]});
      check("hi_tx_d1", {4'd0, tx_d1}, {4'd0, exp_tb[1][3:0]});
      check("rx_dv0", {7'd0, rx_dv0}, {7'd0, exp_dv[0]});
      check("rx_dv1", {7'd0, rx_dv1}, {7'd0, exp_dv[1]});
      check("rx_data0", rx_data0, exp_data[0]);
      check("rx_data1", rx_data1, exp_data[1]);
      rx_ctl = f; rx_d = drv_b[7:4];

      if (mid_rst) begin
         rst = 1'b1;
         #1;
         check_all_zero("midrst");
         @(negedge clk); #2;
      end else begin
         @(negedge clk); #2;
         check("lo_tx_clk", {6'd0, tx_clk1, tx_clk0}, 8'h00);
         check("lo_tx_ctl", {6'd0, tx_ctl1, tx_ctl0}, {6'd0, exp_tv, exp_tv});
         check("lo_tx_d0", {4'd0, tx_d0}, {4'd0, exp_tb[0][7:4]});
         check("lo_tx_d1", {4'd0, tx_d1}, {4'd0, exp_tb[1][7:4]});
      end
   endtask

   task automatic idle(input int n, input bit loopback);
      repeat (n) step(0, 0, 8'h00, 0, 8'h00, loopback, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] rx_bytes [3];
      logic [7:0] burst [4];
      rx_bytes[0] = 8'hA5; rx_bytes[1] = 8'hB6; rx_bytes[2] = 8'hC7;
      burst[0] = 8'h01; burst[1] = 8'h23; burst[2] = 8'h45; burst[3] = 8'h67;
      idle_nib[0] = IDLE0; idle_nib[1] = IDLE1;

      apply_reset(5);
      idle(2, 0);

      // RX single bytes fed straight back into TX.
      for (int i = 0; i < 3; i++) begin
         step(1, 1, rx_bytes[i], 0, 8'h00, 1, 0);
         step(0, 0, 8'h00, 0, 8'h00, 1, 0);
      end
      idle(4, 1);

      // Contiguous TX burst followed by idle nibbles.
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, burst[i], 0, 0);
      idle(3, 0);

      // RX error: valid on rising edge, DV^ER low on falling edge.
      step(1, 0, 8'h3C, 0, 8'h00, 0, 0);
      idle(2, 0);

      // Randomised mixed RX/TX traffic, including occasional error bytes.
      for (int i = 0; i < 300; i++) begin
         bit r, f, tdv;
         r   = ($urandom_range(0, 3) != 0);
         f   = ($urandom_range(0, 7) == 0) ? !r : r;
         tdv = ($urandom_range(0, 2) != 0);
         step(r, f, 8'($urandom), tdv, 8'($urandom), 0, 0);
      end
      idle(2, 0);

      // Reset in the high phase of a TX byte with an RX byte mid-capture.
      step(0, 0, 8'h00, 1, 8'hE1, 0, 0);
      step(1, 1, 8'h5A, 1, 8'hD2, 0, 1);
      apply_reset(3);
      idle(4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
